// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bundle: predictor answer in, fetch PC out, EX resolve in,
// predictor feedback and pipeline flush out.
interface pc_fetch_unit_if;
    logic        stall;
    logic        pred_taken;
    logic [31:0] pred_addr;
    logic [31:0] current_pc;
    logic        fetch_valid;
    logic        resolve_valid;
    logic        resolve_is_branch;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        feedback_enable;
    logic        feedback_branch_taken;
    logic [31:0] feedback_branch_addr;
    logic [31:0] feedback_current_pc;
    logic        flush;
    logic        queue_full;

    // Environment side: pipeline, predictor and EX stage.
    modport master (
        output stall, pred_taken, pred_addr,
        output resolve_valid, resolve_is_branch, resolve_taken, resolve_target,
        input  current_pc, fetch_valid,
        input  feedback_enable, feedback_branch_taken, feedback_branch_addr, feedback_current_pc,
        input  flush, queue_full
    );

    // Fetch unit side.
    modport slave (
        input  stall, pred_taken, pred_addr,
        input  resolve_valid, resolve_is_branch, resolve_taken, resolve_target,
        output current_pc, fetch_valid,
        output feedback_enable, feedback_branch_taken, feedback_branch_addr, feedback_current_pc,
        output flush, queue_full
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencing. Keeps an in-order queue of fetched PCs
// with their predictions, checks each against the EX resolve, redirects
// and flushes on a mispredict, and feeds resolved branches back to the
// predictor one cycle later.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    pc_fetch_unit_if.slave    bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);
    localparam logic [31:0]   WORD_MASK = 32'hFFFF_FFFC;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic          flush_q;
    logic          fb_en_q, fb_taken_q;
    logic [31:0]   fb_addr_q, fb_pc_q;

    logic [31:0]   q_pc    [QDEPTH];
    logic          q_taken [QDEPTH];
    logic [31:0]   q_addr  [QDEPTH];

    logic          full;
    logic          resolve_fire;
    logic          mispredict;
    logic          fetch;
    logic [31:0]   head_pc_plus4;
    logic [31:0]   actual_next;
    logic [31:0]   predicted_next;
    logic [31:0]   pred_addr_m;
    logic [31:0]   target_m;

    // Resolve check against the head entry, fetch acceptance and next-state selection.
    always_comb begin
        full           = (count_q == FULL_CNT);
        resolve_fire   = bus.resolve_valid && (count_q != '0);
        pred_addr_m    = bus.pred_addr & WORD_MASK;
        target_m       = bus.resolve_target & WORD_MASK;
        head_pc_plus4  = q_pc[head_q] + 32'd4;
        actual_next    = (bus.resolve_is_branch && bus.resolve_taken) ? target_m : head_pc_plus4;
        predicted_next = q_taken[head_q] ? q_addr[head_q] : head_pc_plus4;
        mispredict     = resolve_fire && (actual_next != predicted_next);
        fetch          = !reset && !bus.stall && !full && !mispredict;

        pc_d    = pc_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (mispredict) begin
            // Redirect wins over stall; any same-cycle fetch is already suppressed.
            pc_d    = actual_next;
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (fetch) begin
                pc_d   = bus.pred_taken ? pred_addr_m : pc_q + 32'd4;
                tail_d = tail_q + PW'(1);
            end
            if (resolve_fire) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(fetch) - CW'(resolve_fire);
        end
    end

    // PC, queue pointers, flush pulse and predictor feedback registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            flush_q    <= 1'b0;
            fb_en_q    <= 1'b0;
            fb_taken_q <= 1'b0;
            fb_addr_q  <= '0;
            fb_pc_q    <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            flush_q <= mispredict;
            fb_en_q <= resolve_fire && bus.resolve_is_branch;
            if (resolve_fire && bus.resolve_is_branch) begin
                fb_taken_q <= bus.resolve_taken;
                fb_addr_q  <= target_m;
                fb_pc_q    <= q_pc[head_q];
            end
        end
    end

    // Queue payload; entries outside head..tail are don't-care, so no reset needed.
    always_ff @(posedge clk) begin
        if (fetch) begin
            q_pc[tail_q]    <= pc_q;
            q_taken[tail_q] <= bus.pred_taken;
            q_addr[tail_q]  <= pred_addr_m;
        end
    end

    assign bus.current_pc            = pc_q;
    assign bus.fetch_valid           = fetch;
    assign bus.queue_full            = full;
    assign bus.flush                 = flush_q;
    assign bus.feedback_enable       = fb_en_q;
    assign bus.feedback_branch_taken = fb_taken_q;
    assign bus.feedback_branch_addr  = fb_addr_q;
    assign bus.feedback_current_pc   = fb_pc_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed stimulus, a queue-based reference model
// checked every cycle, plus literal expectations along the sequence.
module tb_pc_fetch_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.RESET_PC(32'h0), .QDEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] addr;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pc = 32'h0;
    logic        m_flush = 1'b0;
    logic        m_fb_en = 1'b0;
    logic        m_fb_taken = 1'b0;
    logic [31:0] m_fb_addr = 32'h0;
    logic [31:0] m_fb_pc = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What the resolve this cycle means, from the queue head and the EX inputs.
    task automatic eval_resolve(output bit fire, output bit mis, output logic [31:0] actual);
        logic [31:0] predicted;
        fire = bus.resolve_valid && (mq.size() > 0);
        mis = 1'b0;
        actual = '0;
        if (fire) begin
            actual = (bus.resolve_is_branch && bus.resolve_taken)
                     ? (bus.resolve_target & 32'hFFFF_FFFC) : mq[0].pc + 32'd4;
            predicted = mq[0].taken ? mq[0].addr : mq[0].pc + 32'd4;
            mis = (actual != predicted);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        bit fire, mis, fv;
        logic [31:0] actual;
        if (reset) begin
            mq.delete();
            m_pc = 32'h0;
            m_flush = 1'b0;
            m_fb_en = 1'b0;
            m_fb_taken = 1'b0;
            m_fb_addr = 32'h0;
            m_fb_pc = 32'h0;
        end else begin
            eval_resolve(fire, mis, actual);
            fv = !bus.stall && (mq.size() < 4) && !mis;
            m_fb_en = fire && bus.resolve_is_branch;
            if (m_fb_en) begin
                m_fb_taken = bus.resolve_taken;
                m_fb_addr = bus.resolve_target & 32'hFFFF_FFFC;
                m_fb_pc = mq[0].pc;
            end
            m_flush = mis;
            if (mis) begin
                mq.delete();
                m_pc = actual;
            end else begin
                if (fire) void'(mq.pop_front());
                if (fv) begin
                    mq.push_back('{pc: m_pc, taken: bus.pred_taken,
                                   addr: bus.pred_addr & 32'hFFFF_FFFC});
                    m_pc = bus.pred_taken ? (bus.pred_addr & 32'hFFFF_FFFC) : m_pc + 32'd4;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        bit fire, mis;
        logic [31:0] actual;
        #1;
        if (chk_en) begin
            eval_resolve(fire, mis, actual);
            chk("m_pc", bus.current_pc, m_pc);
            chk("m_fetch_valid", 32'(bus.fetch_valid),
                32'(!reset && !bus.stall && (mq.size() < 4) && !mis));
            chk("m_queue_full", 32'(bus.queue_full), 32'(mq.size() == 4));
            chk("m_flush", 32'(bus.flush), 32'(m_flush));
            chk("m_fb_en", 32'(bus.feedback_enable), 32'(m_fb_en));
            chk("m_fb_taken", 32'(bus.feedback_branch_taken), 32'(m_fb_taken));
            chk("m_fb_addr", bus.feedback_branch_addr, m_fb_addr);
            chk("m_fb_pc", bus.feedback_current_pc, m_fb_pc);
        end
    end

    task automatic drive(input bit s, input bit pt, input logic [31:0] pa,
                         input bit rv, input bit rb, input bit rt, input logic [31:0] tg);
        @(negedge clk);
        bus.stall = s;
        bus.pred_taken = pt;
        bus.pred_addr = pa;
        bus.resolve_valid = rv;
        bus.resolve_is_branch = rb;
        bus.resolve_taken = rt;
        bus.resolve_target = tg;
        #2;
    endtask

    task automatic idle();
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
    endtask

    task automatic stall_idle();
        drive(1, 0, 32'h0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        bus.stall = 0; bus.pred_taken = 0; bus.pred_addr = 0;
        bus.resolve_valid = 0; bus.resolve_is_branch = 0;
        bus.resolve_taken = 0; bus.resolve_target = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        #2;
        // Reset values and sequential fetch.
        chk("rst_pc", bus.current_pc, 32'h0);
        chk("rst_fv", 32'(bus.fetch_valid), 32'd1);
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_fb_en", 32'(bus.feedback_enable), 32'd0);
        chk("rst_fb_addr", bus.feedback_branch_addr, 32'h0);
        chk("rst_fb_pc", bus.feedback_current_pc, 32'h0);
        chk("rst_qf", 32'(bus.queue_full), 32'd0);
        idle(); chk("seq_pc4", bus.current_pc, 32'h4);
        idle(); chk("seq_pc8", bus.current_pc, 32'h8);
        idle(); chk("seq_pc12", bus.current_pc, 32'hC);
        idle(); chk("full_pc", bus.current_pc, 32'h10);
        chk("full_qf", 32'(bus.queue_full), 32'd1);
        chk("full_fv", 32'(bus.fetch_valid), 32'd0);
        idle(); chk("full_hold", bus.current_pc, 32'h10);
        // Pop while full: slot frees only on the following cycle.
        drive(0, 0, 32'h0, 1, 0, 0, 32'h0);
        chk("pop_same_qf", 32'(bus.queue_full), 32'd1);
        chk("pop_same_fv", 32'(bus.fetch_valid), 32'd0);
        idle();
        chk("pop_next_qf", 32'(bus.queue_full), 32'd0);
        chk("pop_next_fv", 32'(bus.fetch_valid), 32'd1);
        // Drain under stall; PC holds, an extra resolve on empty is ignored.
        repeat (4) drive(1, 0, 32'h0, 1, 0, 0, 32'h0);
        chk("stall_pc", bus.current_pc, 32'h14);
        drive(1, 0, 32'h0, 1, 1, 1, 32'h999);
        chk("stall_pc2", bus.current_pc, 32'h14);
        stall_idle();
        chk("empty_fb_en", 32'(bus.feedback_enable), 32'd0);
        chk("empty_flush", 32'(bus.flush), 32'd0);
        // Predicted-taken redirects, resolved correctly.
        drive(0, 1, 32'h100, 0, 0, 0, 32'h0);
        drive(0, 1, 32'h300, 0, 0, 0, 32'h0);
        chk("pt_pc100", bus.current_pc, 32'h100);
        drive(1, 0, 32'h0, 1, 1, 1, 32'h100);
        chk("pt_pc300", bus.current_pc, 32'h300);
        drive(1, 0, 32'h0, 1, 1, 1, 32'h300);
        chk("pt_fb1_pc", bus.feedback_current_pc, 32'h14);
        stall_idle();
        chk("pt_flush", 32'(bus.flush), 32'd0);
        chk("pt_fb_en", 32'(bus.feedback_enable), 32'd1);
        chk("pt_fb_pc", bus.feedback_current_pc, 32'h100);
        chk("pt_fb_addr", bus.feedback_branch_addr, 32'h300);
        chk("pt_fb_taken", 32'(bus.feedback_branch_taken), 32'd1);
        stall_idle();
        chk("pt_fb_drop", 32'(bus.feedback_enable), 32'd0);
        chk("pt_fb_hold", bus.feedback_branch_addr, 32'h300);
        // Direction mispredict with an unaligned resolved target.
        drive(0, 1, 32'h100, 0, 0, 0, 32'h0);
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
        drive(1, 0, 32'h0, 1, 1, 1, 32'h100);
        chk("dm_pc104", bus.current_pc, 32'h104);
        drive(0, 0, 32'h0, 1, 1, 1, 32'h302);
        chk("dm_fv_mis", 32'(bus.fetch_valid), 32'd0);
        drive(1, 0, 32'h0, 1, 1, 1, 32'h554);
        chk("dm_pc", bus.current_pc, 32'h300);
        chk("dm_flush", 32'(bus.flush), 32'd1);
        chk("dm_fb_en", 32'(bus.feedback_enable), 32'd1);
        chk("dm_fb_pc", bus.feedback_current_pc, 32'h100);
        chk("dm_fb_addr", bus.feedback_branch_addr, 32'h300);
        stall_idle();
        chk("dm_flush_1cyc", 32'(bus.flush), 32'd0);
        chk("dm_empty_fb", 32'(bus.feedback_enable), 32'd0);
        chk("dm_empty_addr", bus.feedback_branch_addr, 32'h300);
        // Non-branch predicted taken, resolved under stall.
        drive(0, 1, 32'h40, 0, 0, 0, 32'h0);
        drive(0, 1, 32'h83, 0, 0, 0, 32'h0);
        chk("nb_pc40", bus.current_pc, 32'h40);
        drive(1, 0, 32'h0, 1, 1, 1, 32'h40);
        chk("nb_pc80", bus.current_pc, 32'h80);
        drive(1, 0, 32'h0, 1, 0, 0, 32'h0);
        stall_idle();
        chk("nb_pc", bus.current_pc, 32'h44);
        chk("nb_flush", 32'(bus.flush), 32'd1);
        chk("nb_fb_en", 32'(bus.feedback_enable), 32'd0);
        // Async reset with three entries queued and feedback pending.
        idle(); idle(); idle();
        drive(0, 0, 32'h0, 1, 1, 0, 32'h0);
        chk("ar_pre_pc", bus.current_pc, 32'h50);
        reset = 1'b1;
        #1;
        chk("ar_pc", bus.current_pc, 32'h0);
        chk("ar_fv", 32'(bus.fetch_valid), 32'd0);
        chk("ar_qf", 32'(bus.queue_full), 32'd0);
        chk("ar_fb_en", 32'(bus.feedback_enable), 32'd0);
        chk("ar_flush", 32'(bus.flush), 32'd0);
        chk("ar_fb_pc", bus.feedback_current_pc, 32'h0);
        chk("ar_fb_addr", bus.feedback_branch_addr, 32'h0);
        @(negedge clk);
        bus.resolve_valid = 0; bus.resolve_is_branch = 0;
        reset = 1'b0;
        #2;
        chk("ar_post_fb", 32'(bus.feedback_enable), 32'd0);
        chk("ar_post_pc", bus.current_pc, 32'h0);
        idle();
        chk("ar_post_fb2", 32'(bus.feedback_enable), 32'd0);
        chk("ar_post_pc4", bus.current_pc, 32'h4);
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
